// File: rtl/soc_fact_unit.sv
// Memory-mapped factorial accelerator: N / GO / STATUS / RESULT registers, one multiply per cycle.
// Optional one-cycle completion interrupt output irq when SOC_FACT_IRQ_EN is defined.
module soc_fact_unit #(
    parameter int NW    = 4,
    parameter int MAX_N = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
`ifdef SOC_FACT_IRQ_EN
    output logic        irq,
`endif
    output logic [31:0] rd
);

    localparam logic [1:0]    REG_N      = 2'b00;
    localparam logic [1:0]    REG_GO     = 2'b01;
    localparam logic [1:0]    REG_STATUS = 2'b10;
    localparam logic [NW-1:0] ONE        = NW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, MULT, DONE} state_t;

    state_t        state, state_d;
    logic [NW-1:0] n, n_d, operand, operand_d, count, count_d;
    logic          go, go_d, done, done_d, err, err_d;
    logic [31:0]   result, result_d, product, product_d;
    logic          irq_q, irq_d;
    logic          unused_wd;

    assign unused_wd = ^wd[31:NW];

    function automatic logic [31:0] mul_lo(input logic [31:0] p, input logic [NW-1:0] c);
        logic [31:0] cw;
        cw = {{(32-NW){1'b0}}, c};
        return p * cw;
    endfunction

    always_comb begin
        state_d   = state;
        n_d       = n;
        operand_d = operand;
        count_d   = count;
        go_d      = go;
        done_d    = done;
        err_d     = err;
        result_d  = result;
        product_d = product;

        // N is writable in every state; only the latched operand is protected during a run
        if (we && a == REG_N)
            n_d = wd[NW-1:0];

        case (state)
            IDLE, DONE: begin
                if (we && a == REG_GO) begin
                    go_d = wd[0];
                    if (wd[0]) begin
                        done_d    = 1'b0;
                        err_d     = 1'b0;
                        operand_d = n;
                        state_d   = LOAD;
                    end
                end
            end
            LOAD: begin
                if ({{(32-NW){1'b0}}, operand} > 32'(MAX_N)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    done_d   = 1'b1;
                    go_d     = 1'b0;
                    state_d  = DONE;
                end else begin
                    product_d = 32'd1;
                    count_d   = operand;
                    state_d   = MULT;
                end
            end
            MULT: begin
                if (count <= ONE) begin
                    result_d = product;
                    done_d   = 1'b1;
                    go_d     = 1'b0;
                    state_d  = DONE;
                end else begin
                    product_d = mul_lo(product, count);
                    count_d   = count - ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        irq_d = (state != DONE) && (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            n       <= '0;
            operand <= '0;
            count   <= '0;
            go      <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
            product <= '0;
            irq_q   <= 1'b0;
        end else begin
            state   <= state_d;
            n       <= n_d;
            operand <= operand_d;
            count   <= count_d;
            go      <= go_d;
            done    <= done_d;
            err     <= err_d;
            result  <= result_d;
            product <= product_d;
            irq_q   <= irq_d;
        end
    end

`ifdef SOC_FACT_IRQ_EN
    assign irq = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_q;
`endif

    always_comb begin
        rd = '0;
        case (a)
            REG_N:      rd = {{(32-NW){1'b0}}, n};
            REG_GO:     rd = {31'b0, go};
            REG_STATUS: rd = {30'b0, err, done};
            default:    rd = result;
        endcase
    end

endmodule

// File: tb/tb_soc_fact_unit.sv
// Scoreboard bench for soc_fact_unit: stimulus queues expected jobs/reads, a negedge monitor checks them.
module tb_soc_fact_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [1:0]  a   = 2'b10;
    logic [31:0] wd  = '0;
    logic [31:0] rd;
`ifdef SOC_FACT_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    soc_fact_unit #(.NW(4), .MAX_N(12)) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .a(a),
        .wd(wd),
`ifdef SOC_FACT_IRQ_EN
        .irq(irq),
`endif
        .rd(rd)
    );

    typedef struct {
        int          go_cyc;
        int          lat;
        logic        err;
        logic [31:0] res;
    } job_t;

    typedef struct {
        logic [1:0]  a;
        logic [31:0] exp;
        string       name;
    } rchk_t;

    job_t  jq[$];
    rchk_t rq[$];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_events = 0;
    int   tmo_events = 0;
    int   tmo_seen = 0;
    logic prev_done = 1'b0;

    int          model_n = 0;
    bit          model_busy = 1'b0;
    logic [31:0] model_result = '0;
    logic        model_err = 1'b0;
    logic [31:0] cur_res = '0;
    logic        cur_err = 1'b0;

    always @(posedge clk) cyc++;

    // Reference: n! with plain arithmetic, done latency max(n,1)+1, error latency 1
    function automatic job_t model(input int n, input int gc);
        job_t j;
        j.go_cyc = gc;
        if (n > 12) begin
            j.err = 1'b1;
            j.res = '0;
            j.lat = 1;
        end else begin
            j.err = 1'b0;
            j.res = 32'd1;
            for (int i = 2; i <= n; i++) j.res = j.res * 32'(i);
            j.lat = ((n < 1) ? 1 : n) + 1;
        end
        return j;
    endfunction

    always @(negedge clk) begin
        job_t  j;
        rchk_t r;
        bit    e;
        if (tmo_events != tmo_seen) begin
            tmo_seen = tmo_events;
            checks++;
            failures++;
            $display("FAIL done_timeout got=no_done required=done_within_bound");
        end
        if (rst) begin
            jq.delete();
            prev_done = 1'b0;
        end
`ifdef SOC_FACT_IRQ_EN
        e = (jq.size() > 0) && (cyc == jq[0].go_cyc + jq[0].lat);
        checks++;
        if (irq !== e) begin
            failures++;
            $display("FAIL irq cyc=%0d got=%b required=%b", cyc, irq, e);
        end
`else
        e = 1'b0;
`endif
        if (rq.size() > 0) begin
            r = rq.pop_front();
            checks++;
            if (a !== r.a || rd !== r.exp) begin
                failures++;
                $display("FAIL %s a=%0d got=%h required=%h", r.name, a, rd, r.exp);
            end
        end else if (a == 2'b10) begin
            if (rd[0] === 1'b1 && !prev_done) begin
                if (jq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done got=done required=no_pending_done");
                end else begin
                    j = jq.pop_front();
                    checks++;
                    if ((cyc - j.go_cyc) != j.lat || rd[1] !== j.err) begin
                        failures++;
                        $display("FAIL done_latency got=%0d/err=%b required=%0d/err=%b",
                                 cyc - j.go_cyc, rd[1], j.lat, j.err);
                    end
                    done_events++;
                end
            end
            prev_done = rd[0];
        end
    end

    task automatic wr(input logic [1:0] addr, input logic [31:0] d);
        job_t j;
        we = 1'b1;
        a  = addr;
        wd = d;
        if (addr == 2'b00) model_n = int'(d[3:0]);
        if (addr == 2'b01 && !model_busy && d[0]) begin
            j = model(model_n, cyc + 1);
            jq.push_back(j);
            cur_res    = j.res;
            cur_err    = j.err;
            model_busy = 1'b1;
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        a  = 2'b10;
        wd = '0;
    endtask

    task automatic chk(input logic [1:0] addr, input logic [31:0] e, input string nm);
        rchk_t r;
        r.a = addr;
        r.exp = e;
        r.name = nm;
        a = addr;
        rq.push_back(r);
        @(posedge clk);
        #1;
        a = 2'b10;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        int de;
        de = done_events;
        for (int i = 0; i < 40 && done_events == de; i++) begin
            @(posedge clk);
            #1;
        end
        if (done_events == de) tmo_events++;
        model_busy   = 1'b0;
        model_result = cur_res;
        model_err    = cur_err;
    endtask

    task automatic run(input logic [31:0] nword);
        wr(2'b00, nword);
        wr(2'b01, 32'd1);
        wait_done();
        chk(2'b11, model_result, "result");
        chk(2'b10, {30'b0, model_err, 1'b1}, "status");
        chk(2'b01, 32'd0, "go_after");
        chk(2'b00, {28'b0, nword[3:0]}, "n_reg");
    endtask

    task automatic reset_reads();
        chk(2'b00, 32'd0, "rst_n");
        chk(2'b01, 32'd0, "rst_go");
        chk(2'b10, 32'd0, "rst_status");
        chk(2'b11, 32'd0, "rst_result");
        rst = 1'b0;
        model_busy   = 1'b0;
        model_n      = 0;
        model_result = '0;
        idle(1);
    endtask

    initial begin
        logic [31:0] d;
        int          nn;
        @(posedge clk);
        #1;
        reset_reads();

        wr(2'b10, 32'hFFFF_FFFF);
        wr(2'b11, 32'hFFFF_FFFF);
        chk(2'b10, 32'd0, "ro_status_init");
        chk(2'b11, 32'd0, "ro_result_init");

        wr(2'b00, 32'd5);
        wr(2'b01, 32'd1);
        chk(2'b01, 32'd1, "go_busy");
        wait_done();
        chk(2'b11, 32'h0000_0078, "result_5");
        chk(2'b01, 32'd0, "go_after_5");
        chk(2'b10, 32'd1, "status_5");

        run(32'd0);
        run(32'd1);
        run(32'd12);
        run(32'd13);
        chk(2'b11, 32'd0, "result_13");

        wr(2'b00, 32'd10);
        wr(2'b01, 32'd1);
        idle(2);
        wr(2'b00, 32'd2);
        wr(2'b01, 32'd1);
        wait_done();
        chk(2'b11, 32'h0037_5F00, "result_10_overlap");
        chk(2'b00, 32'd2, "n_after_overlap");
        wr(2'b01, 32'd1);
        wait_done();
        chk(2'b11, 32'd2, "result_2");

        wr(2'b10, 32'hFFFF_FFFF);
        wr(2'b11, 32'hFFFF_FFFF);
        chk(2'b11, 32'd2, "ro_result");
        chk(2'b10, 32'd1, "ro_status");

        wr(2'b00, 32'd8);
        wr(2'b01, 32'd1);
        idle(2);
        rst = 1'b1;
        reset_reads();
        run(32'd3);

        repeat (12) begin
            nn = int'($urandom_range(0, 15));
            d = $urandom;
            d[3:0] = nn[3:0];
            if ($urandom_range(0, 2) == 0) begin
                wd = $urandom;
                wr(2'b01, wd & 32'hFFFF_FFFE);
                chk(2'b01, 32'd0, "go_clear");
            end
            run(d);
        end

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
